serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around one full_adder cell plus a carry flip-flop.
//   Operands load in parallel and are added LSB-first, one bit per clock.
//   Result is presented in parallel with a one-cycle DONE pulse.
//   Sits downstream of the half/full adder cells: consumes the full_adder S/Cout each cycle.
//   Trades latency for area versus a ripple adder.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits, >= 1
// PORTS
//   CLK    in   1      rising-edge clock
//   RST    in   1      asynchronous reset, active-high
//   START  in   1      request; accepted only when READY=1
//   A      in   WIDTH  operand A, sampled on the accepting edge
//   B      in   WIDTH  operand B, sampled on the accepting edge
//   Cin    in   1      carry-in, sampled on the accepting edge
//   READY  out  1      1 in IDLE and DONE states (new START accepted)
//   BUSY   out  1      1 in SHIFT state
//   DONE   out  1      one-cycle pulse: SUM/Cout valid and newly updated
//   SUM    out  WIDTH  registered result, held until next completion
//   Cout   out  1      registered carry-out, held with SUM
// BEHAVIOUR
//   Reset (async, RST=1): state=IDLE, shift regs=0, carry FF=0, bit counter=0,
//     SUM=0, Cout=0, DONE=0, BUSY=0, READY=1. Reset mid-SHIFT aborts; no DONE issued.
//   FSM: IDLE -> SHIFT on START&READY; SHIFT -> DONE after WIDTH bit cycles;
//     DONE -> SHIFT if START, else IDLE. DONE lasts exactly one cycle.
//   Accept edge: a_sr<=A, b_sr<=B, carry<=Cin, cnt<=0, s_sr<=0.
//   Each SHIFT edge: {c,s}=full_adder(a_sr[0],b_sr[0],carry); s_sr<={s,s_sr[WIDTH-1:1]};
//     a_sr,b_sr shift right by 1; carry<=c; cnt<=cnt+1.
//   Last SHIFT edge (cnt==WIDTH-1): SUM<=final {s,s_sr[WIDTH-1:1]}, Cout<=c, state<=DONE.
//   Latency: START accepted at edge 0 -> DONE high for the cycle after edge WIDTH.
//     For WIDTH=8, DONE is high between edges 8 and 9.
//   Throughput: back-to-back; START during DONE is accepted at that edge.
//     The next DONE follows WIDTH+1 cycles later.
//   START while BUSY is ignored. Operand/Cin changes while BUSY have no effect.
//   SUM/Cout change only on the edge entering DONE; stable otherwise, including during SHIFT.
//   Arithmetic: {Cout,SUM} = A + B + Cin, modulo 2^(WIDTH+1); exact, no saturation.
//   cnt width: $clog2(WIDTH+1). WIDTH=1: one SHIFT cycle, then DONE.
//   Outputs READY/BUSY/DONE decoded from registered state only; no combinational input-to-output path.
// TESTING (WIDTH=8)
//   1. START with A=0x0F, B=0x01, Cin=0 -> DONE 8 edges later; SUM=0x10, Cout=0; BUSY high 8 cycles.
//   2. A=0xFF, B=0x01, Cin=0 -> SUM=0x00, Cout=1; then A=0xFF, B=0xFF, Cin=1 -> SUM=0xFF, Cout=1.
//   3. START again at cycle 3 of a busy op with A=0x55 -> ignored.
//      Original A=0x12, B=0x34 gives SUM=0x46; only one DONE pulse.
//   4. Assert RST for 1 cycle at cycle 4 of an op -> READY=1, BUSY=0, SUM=0, Cout=0, no DONE.
//      A following 0x01+0x01 gives SUM=0x02.
//   5. START held high across DONE with a new operand pair 0x80+0x80 -> accepted at the DONE edge.
//      Second DONE 9 cycles after the first; SUM=0x00, Cout=1; first result held until then.
//   6. Exhaustive WIDTH=2 build: all 32 {A,B,Cin} combinations -> {Cout,SUM} == A+B+Cin.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, LSB first, one bit per clock.
// Latency WIDTH+1 cycles from accept to DONE; START only taken while READY, ignored while BUSY.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_cat;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last, accept;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // Sum bits enter at the MSB and walk down; a 1-bit adder has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_cat = fa_s;
    end else begin : g_wn
      assign s_cat = {fa_s, s_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = START && (state != S_SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_SHIFT;
      S_SHIFT: if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = START ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      Cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= A;
        b_sr  <= B;
        carry <= Cin;
        cnt   <= '0;
        s_sr  <= '0;
      end else if (state == S_SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= s_cat;
        carry <= fa_c;
        cnt   <= cnt + CW'(1);
        if (last) begin
          SUM  <= s_cat;
          Cout <= fa_c;
        end
      end
    end
  end

  // Status decoded from the state register only.
  assign READY = (state != S_SHIFT);
  assign BUSY  = (state == S_SHIFT);
  assign DONE  = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8) plus an exhaustive WIDTH=2 instance.
module tb_serial_adder;
  logic       CLK = 1'b0;
  logic       RST, START, Cin;
  logic [7:0] A, B, SUM;
  logic       READY, BUSY, DONE, Cout;

  logic       start2, cin2, ready2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  integer checks = 0;
  integer errors = 0;

  always #5 CLK = ~CLK;

  serial_adder #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .Cin(Cin),
    .READY(READY), .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .Cout(Cout)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .START(start2), .A(a2), .B(b2), .Cin(cin2),
    .READY(ready2), .BUSY(busy2), .DONE(done2), .SUM(sum2), .Cout(cout2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete operation; START is pulsed for a single edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec);
    int n, busy_n;
    logic stable;
    logic [7:0] held;
    @(negedge CLK);
    check("ready_before_start", {31'd0, READY}, 32'd1);
    START = 1'b1; A = a; B = b; Cin = ci;
    @(negedge CLK);
    START = 1'b0; A = ~a; B = ~b; Cin = ~ci;
    held = SUM; stable = 1'b1; n = 0; busy_n = 0;
    while (!DONE && n < 20) begin
      if (BUSY) busy_n++;
      if (SUM !== held) stable = 1'b0;
      @(negedge CLK);
      n++;
    end
    check("done_latency", n, 32'd8);
    check("busy_cycles", busy_n, 32'd8);
    check("sum_stable_while_busy", {31'd0, stable}, 32'd1);
    check("sum", {24'd0, SUM}, {24'd0, es});
    check("cout", {31'd0, Cout}, {31'd0, ec});
    @(negedge CLK);
    check("done_one_cycle", {31'd0, DONE}, 32'd0);
  endtask

  task automatic run_w2(input logic [1:0] a, input logic [1:0] b, input logic ci);
    int n;
    logic [2:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {2'b00, ci};
    @(negedge CLK);
    start2 = 1'b1; a2 = a; b2 = b; cin2 = ci;
    @(negedge CLK);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("w2_latency", n, 32'd2);
    check("w2_result", {29'd0, cout2, sum2}, {29'd0, exp});
    @(negedge CLK);
  endtask

  initial begin
    int n, dones;
    logic [7:0] sum_at_done;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[9] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};

    RST = 1'b1; START = 1'b0; A = '0; B = '0; Cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ready", {31'd0, READY}, 32'd1);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_sum", {24'd0, SUM}, 32'd0);
    check("rst_cout", {31'd0, Cout}, 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // START during SHIFT with different operands must be ignored.
    @(negedge CLK);
    START = 1'b1; A = 8'h12; B = 8'h34; Cin = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    START = 1'b1; A = 8'h55;
    @(negedge CLK);
    START = 1'b0; A = 8'h00;
    dones = 0; sum_at_done = 8'h00;
    for (int i = 0; i < 15; i++) begin
      if (DONE) begin dones++; sum_at_done = SUM; end
      @(negedge CLK);
    end
    check("ignored_start_dones", dones, 32'd1);
    check("ignored_start_sum", {24'd0, sum_at_done}, 32'h46);

    // Reset mid-operation aborts without a DONE.
    @(negedge CLK);
    START = 1'b1; A = 8'h0F; B = 8'h0F; Cin = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_ready", {31'd0, READY}, 32'd1);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    check("midrst_sum", {24'd0, SUM}, 32'd0);
    check("midrst_cout", {31'd0, Cout}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE) dones++;
      @(negedge CLK);
    end
    check("midrst_no_done", dones, 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // START held high across DONE: back-to-back accept.
    @(negedge CLK);
    START = 1'b1; A = 8'h21; B = 8'h10; Cin = 1'b0;
    @(negedge CLK);
    A = 8'h80; B = 8'h80;
    n = 0;
    while (!DONE && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_first_latency", n, 32'd8);
    check("b2b_first_sum", {24'd0, SUM}, 32'h31);
    n = 0; dones = 0;
    do begin
      @(negedge CLK);
      n++;
      if (!DONE && SUM !== 8'h31) dones++;
    end while (!DONE && n < 20);
    START = 1'b0;
    check("b2b_second_spacing", n, 32'd9);
    check("b2b_first_held", dones, 32'd0);
    check("b2b_second_sum", {24'd0, SUM}, 32'h00);
    check("b2b_second_cout", {31'd0, Cout}, 32'd1);
    @(negedge CLK);
    check("b2b_idle_after", {31'd0, READY & ~DONE}, 32'd1);

    for (int v = 0; v < 32; v++) begin
      logic [4:0] c;
      c = v[4:0];
      run_w2(c[4:3], c[2:1], c[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
